load_store_unit: RTL and testbench

//  Memory stage directly downstream of the ALU: takes the ALU_ADD result as effective address,

---
 rtl/load_store_unit_pkg.sv | 68 ++++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared core types: ALU control, LSU state encoding, RV32I memory width codes
// and small helpers for lane/byte-enable generation and alignment checks.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_control_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } mem_width_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT_R = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } lsu_state_t;

    // Reserved width codes are treated as faults so they never reach memory.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic fault;
        case (funct3)
            F3_LB, F3_LBU: fault = 1'b0;
            F3_LH, F3_LHU: fault = off[0];
            F3_LW:         fault = (off != 2'b00);
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

    // funct3[1:0] encodes the access size for both signed and unsigned variants.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating across lanes lets memory pick the bytes purely from mem_be.
    function automatic logic [31:0] lane_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects the addressed byte/half from the raw
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] word
);

    logic [31:0] shifted;
    logic        sext;

    // Shift the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        sext    = ~funct3[2];
        case (funct3[1:0])
            2'b00:   word = {{24{shifted[7] & sext}}, shifted[7:0]};
            2'b01:   word = {{16{shifted[15] & sext}}, shifted[15:0]};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one outstanding data-memory transaction per request over a
// req/gnt + rvalid bus, misalignment faulting and load data extension.
//
// state  | meaning
// IDLE   | ready for a new request (req_ready=1)
// REQ    | mem_req asserted, waiting for mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid
// DONE   | resp_valid pulse with load data (0 for stores)
// FAULT  | resp_valid + resp_misal pulse, memory untouched
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_misal,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t       state, state_nxt;
    logic             accept;
    logic             misal;
    logic [2:0]       cap_funct3;
    logic [1:0]       cap_off;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] load_word;

    assign accept = req_valid & (state == IDLE);
    assign misal  = is_misaligned(req_funct3, req_addr[1:0]);

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .off    (cap_off),
        .funct3 (cap_funct3),
        .word   (load_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; gnt/rvalid only matter in the state that waits for them.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misal ? FAULT : REQ;
            REQ:     if (mem_gnt) state_nxt = we_q ? DONE : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture request fields at accept and load data on rvalid. Faulting
    // requests leave the memory-side registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_funct3 <= '0;
            cap_off    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                cap_funct3 <= req_funct3;
                cap_off    <= req_addr[1:0];
                rdata_q    <= '0;
                if (!misal) begin
                    we_q    <= req_store;
                    addr_q  <= {req_addr[WIDTH-1:2], 2'b00};
                    be_q    <= byte_enables(req_funct3, req_addr[1:0]);
                    wdata_q <= req_store ? lane_data(req_funct3, req_wdata) : '0;
                end
            end
            if (state == WAIT_R && mem_rvalid) rdata_q <= load_word;
        end
    end

    assign req_ready  = (state == IDLE);
    assign mem_req    = (state == REQ);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state == DONE) || (state == FAULT);
    assign resp_misal = (state == FAULT);
    assign resp_rdata = (state == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of request vectors with
// hand-computed bus fields, responses and latencies, plus reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misal;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_misal (resp_misal),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_delay;
        int          rv_gap;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_misal;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc, req_cnt, g, exp_cyc;
        bit  got, saw_req;
        cyc = 0; req_cnt = 0; g = 0; got = 0; saw_req = 0;
        exp_cyc = v.exp_misal ? 1 : (v.store ? 2 + v.gnt_delay : 3 + v.gnt_delay + v.rv_gap);
        @(negedge clk);
        check({v.name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        check({v.name, " idle_resp"}, {31'b0, resp_valid}, 32'd0);
        req_valid  = 1'b1;
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hDEAD_0000;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (mem_req) begin
                if (!saw_req) begin
                    check({v.name, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
                    check({v.name, " mem_be"}, {28'b0, mem_be}, {28'b0, v.exp_be});
                    check({v.name, " mem_we"}, {31'b0, mem_we}, {31'b0, v.store});
                    if (v.store) check({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
                end
                saw_req = 1;
                if (req_cnt == v.gnt_delay) begin
                    mem_gnt = 1'b1;
                    g = cyc;
                end
                req_cnt++;
            end
            if (!v.store && g > 0 && cyc == g + 1 + v.rv_gap) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
            end
            if (resp_valid) begin
                got = 1;
                check({v.name, " latency"}, cyc, exp_cyc);
                check({v.name, " resp_rdata"}, resp_rdata, v.exp_rdata);
                check({v.name, " resp_misal"}, {31'b0, resp_misal}, {31'b0, v.exp_misal});
                check({v.name, " req_cycles"}, req_cnt, v.exp_misal ? 0 : v.gnt_delay + 1);
            end
        end
        if (!got) check({v.name, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{"LW_1000",   1'b0, 3'b010, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 0, 1, 4'b1111, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{"LB_1003",   1'b0, 3'b000, 32'h0000_1003, 32'h0,          32'h80FF_0000, 0, 0, 4'b1000, 32'h0,          32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{"LBU_1003",  1'b0, 3'b100, 32'h0000_1003, 32'h0,          32'h80FF_0000, 1, 2, 4'b1000, 32'h0,          32'h0000_0080, 1'b0};
        vecs[3]  = '{"SH_2002",   1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD,  32'h0,         3, 0, 4'b1100, 32'hABCD_ABCD,  32'h0,         1'b0};
        vecs[4]  = '{"LW_1001",   1'b0, 3'b010, 32'h0000_1001, 32'h0,          32'h0,         0, 0, 4'b0000, 32'h0,          32'h0,         1'b1};
        vecs[5]  = '{"SB_3001",   1'b1, 3'b000, 32'h0000_3001, 32'h1122_33A5,  32'h0,         0, 0, 4'b0010, 32'hA5A5_A5A5,  32'h0,         1'b0};
        vecs[6]  = '{"LHU_3002",  1'b0, 3'b101, 32'h0000_3002, 32'h0,          32'h8001_0000, 0, 0, 4'b1100, 32'h0,          32'h0000_8001, 1'b0};
        vecs[7]  = '{"LH_3002",   1'b0, 3'b001, 32'h0000_3002, 32'h0,          32'h8001_0000, 2, 1, 4'b1100, 32'h0,          32'hFFFF_8001, 1'b0};
        vecs[8]  = '{"LH_0003",   1'b0, 3'b001, 32'h0000_0003, 32'h0,          32'h0,         0, 0, 4'b0000, 32'h0,          32'h0,         1'b1};
        vecs[9]  = '{"F3_011",    1'b0, 3'b011, 32'h0000_0000, 32'h0,          32'h0,         0, 0, 4'b0000, 32'h0,          32'h0,         1'b1};
        vecs[10] = '{"SW_4004",   1'b1, 3'b010, 32'h0000_4004, 32'hCAFE_F00D,  32'h0,         1, 0, 4'b1111, 32'hCAFE_F00D,  32'h0,         1'b0};
        vecs[11] = '{"LB_4000",   1'b0, 3'b000, 32'h0000_4000, 32'h0,          32'h1234_567F, 0, 0, 4'b0001, 32'h0,          32'h0000_007F, 1'b0};
        vecs[12] = '{"LHU_5000",  1'b0, 3'b101, 32'h0000_5000, 32'h0,          32'h1234_FFFF, 0, 0, 4'b0011, 32'h0,          32'h0000_FFFF, 1'b0};
        vecs[13] = '{"SW_5002",   1'b1, 3'b010, 32'h0000_5002, 32'h0BAD_0BAD,  32'h0,         0, 0, 4'b0000, 32'h0,          32'h0,         1'b1};
        vecs[14] = '{"SB_6002",   1'b1, 3'b000, 32'hFFFF_6002, 32'h0000_0011,  32'h0,         0, 0, 4'b0100, 32'h1111_1111,  32'h0,         1'b0};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_misal", {31'b0, resp_misal}, 32'd0);
        check("rst mem_req",    {31'b0, mem_req},    32'd0);
        check("rst mem_we",     {31'b0, mem_we},     32'd0);
        check("rst mem_be",     {28'b0, mem_be},     32'd0);
        check("rst mem_addr",   mem_addr,   32'd0);
        check("rst mem_wdata",  mem_wdata,  32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);

        // Main table, applied back-to-back.
        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Reset while mem_req is up: request must drop without waiting for a clock.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h7000;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstreq mem_req_before", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstreq mem_req_after", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WAIT_R, then stray gnt/rvalid in IDLE are ignored.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6000;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstwr mem_req", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rstwr in_wait_r", {30'b0, mem_req, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rstwr resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rstwr mem_req_now", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray resp_valid", {31'b0, resp_valid}, 32'd0);
            check("stray mem_req",    {31'b0, mem_req},    32'd0);
            check("stray req_ready",  {31'b0, req_ready},  32'd1);
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;

        // Unit still functional after the reset sequences.
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
